mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares the single memory port of the multicycle CPU between two requesters: port C (CPU, `madr`/`tomem`/`frommem`/`wmem` side) and port D (DMA/debug loader). It runs one memory transaction at a time through a req/ready handshake to the memory, returns read data and a one-cycle acknowledge to the winning requester, and aborts hung transactions with a wait-state watchdog. The block sits between the CPU memory interface and the memory model; the CPU's control unit holds its state until `c_ack`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 16, max BUSY cycles without `m_ready` before abort (≥1)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `c_req`, `d_req`  in  1  transaction request, held until matching ack
- `c_we`, `d_we`  in  1  1 = write, 0 = read
- `c_addr`, `d_addr`  in  AW  byte address
- `c_wdata`, `d_wdata`  in  DW  write data
- `c_rdata`, `d_rdata`  out  DW  read data, valid with ack
- `c_ack`, `d_ack`  out  1  one-cycle completion pulse
- `err`  out  1  watchdog abort, valid only with an ack
- `m_req`  out  1  memory request, high throughout BUSY
- `m_we`, `m_addr`, `m_wdata`  out  1/AW/DW  latched transaction fields
- `m_rdata`  in  DW  memory read data, sampled with `m_ready`
- `m_ready`  in  1  memory completion, sampled only in BUSY
- `owner`  out  1  0 = C, 1 = D; current/last granted port
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: if either req high, select winner, latch its `we/addr/wdata` into `m_*`, set `owner`, clear wait counter, → BUSY. No req → stay.
- Selection: only C → C; only D → D; both → per Configuration.
- BUSY: `m_req`=1. `m_ready`=1 → capture `m_rdata` (reads; writes capture nothing, rdata holds), `err`=0, → DONE. Else counter+1; on MAX_WAIT-th BUSY cycle without ready → `err`=1, rdata=0, → DONE. Ready and limit in same cycle: ready wins, err=0.
- DONE: ack of `owner` high for exactly this cycle, rdata driven on owner's port, → IDLE. Other port's ack stays 0.
- Requests sampled only in IDLE; req changes in BUSY/DONE ignored. Requester holding req after its ack starts a new transaction.
- Counter width `$clog2(MAX_WAIT+1)`, saturates; never wraps.
- Reset mid-transaction: immediate return to IDLE, `m_req` drops asynchronously, transaction abandoned, no ack issued.
- Reset values: all outputs 0 (`m_*`, rdata, acks, `err`, `busy`, `owner`=0); RR pointer = "D last" so C wins the first tie.

## Timing
- Req seen high in IDLE at cycle T → `m_req` high from T+1.
- `m_ready` at T+k (k≥1) → ack and rdata at T+k+1, IDLE at T+k+2.
- Minimum latency req→ack: 2 cycles; back-to-back throughput: one transaction per 3 cycles minimum.
- Abort: ack with `err` at T+MAX_WAIT+1.
- `m_ready` in IDLE/DONE ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on ties; winner is the port not granted last; pointer updated at each grant.
- Undefined: fixed priority, C always wins ties (D may starve while C requests continuously).

## Structure
- Shared package: state encoding typedef (IDLE/BUSY/DONE), port-ID constants `PORT_C`=0/`PORT_D`=1, abort read value constant (0).
- One sub-module: `arb2_pick` (combinational 2-way picker with RR pointer input, `MEM_ARB_RR_EN` selects behaviour). Rest is the FSM, latch registers and watchdog counter in the top.

## Test plan
- C read only, addr 0x100, `m_ready` 1 cycle after `m_req`, `m_rdata`=0x12345678 → `c_ack` 2 cycles after req, `c_rdata`=0x12345678, `err`=0, `d_ack`=0.
- D write addr 0x40 data 0xCAFEBABE, ready after 3 waits → `m_we`=1, `m_addr`=0x40, `m_wdata`=0xCAFEBABE held all BUSY; `d_ack` at T+5.
- C and D request together continuously → with `MEM_ARB_RR_EN`: acks alternate C,D,C,D; without: C only, D never acked.
- `m_ready` never asserted, MAX_WAIT=16 → ack at T+17 with `err`=1, rdata=0; next request served normally.
- Reset asserted in mid-BUSY → `m_req`, `busy` fall immediately, no ack; after release, first tie goes to C.
- `m_ready` pulsed in IDLE and DONE → no state change, no spurious ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding, port IDs, abort data.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Arbiter FSM encoding, kept as plain constants for compatibility with older consumers.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_DONE = 2'd2;

  // Port identifiers as carried on `owner` and the round-robin pointer.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Read data returned to the requester when the watchdog aborts a transaction.
  localparam int unsigned ABORT_RDATA = 0;

endpackage

// File: rtl/mem_port_arbiter_arb2_pick.sv
// Combinational 2-way picker between port C and port D; MEM_ARB_RR_EN selects round-robin ties.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
module arb2_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req_c,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_port
);

  assign grant_vld = req_c | req_d;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_port = req_c ? PORT_C : PORT_D;
    if (req_c && req_d) begin
      grant_port = (last_grant == PORT_D) ? PORT_C : PORT_D;
    end
  end
`else
  // Fixed priority: C wins every tie, so the pointer is not consulted.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Single requester wins outright; with both requesting, C wins.
  always_comb begin
    grant_port = req_c ? PORT_C : PORT_D;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU (C) and DMA/loader (D); ties by priority or MEM_ARB_RR_EN round-robin.
// Latency: req->ack 2 cycles minimum (IDLE, BUSY, DONE); watchdog abort ack at MAX_WAIT+1.
// Backpressure: requesters hold req until their ack; memory stalls via m_ready, bounded by the watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          owner,
  output logic          busy
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // Counter value seen on the last permitted stalled BUSY cycle.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);

  arb_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          pick_vld;
  logic          pick_port;
  logic          in_idle;
  logic          in_busy;
  logic          in_done;
  logic          grant;
  logic          timeout;

  arb2_pick u_pick (
    .req_c      (c_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant_vld  (pick_vld),
    .grant_port (pick_port)
  );

  assign in_idle = (state == ST_IDLE);
  assign in_busy = (state == ST_BUSY);
  assign in_done = (state == ST_DONE);
  assign grant   = in_idle & pick_vld;
  // Ready takes precedence over the watchdog when both land on the same cycle.
  assign timeout = in_busy & ~m_ready & (wait_cnt == WAIT_LAST);

  // State advance: one transaction at a time, IDLE -> BUSY -> DONE -> IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) state <= ST_BUSY;
        ST_BUSY: if (m_ready || timeout) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Latch the winning requester's fields and remember who was granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      owner      <= PORT_C;
      last_grant <= PORT_D;
    end else if (grant) begin
      owner      <= pick_port;
      last_grant <= pick_port;
      if (pick_port == PORT_D) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else begin
        m_we    <= c_we;
        m_addr  <= c_addr;
        m_wdata <= c_wdata;
      end
    end
  end

  // Watchdog: count stalled BUSY cycles, cleared at each grant, saturating rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (grant) begin
      wait_cnt <= '0;
    end else if (in_busy && !m_ready && wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Capture the transaction result; writes leave the read-data register untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (in_busy && m_ready) begin
      err_q <= 1'b0;
      if (!m_we) rdata_q <= m_rdata;
    end else if (timeout) begin
      err_q   <= 1'b1;
      rdata_q <= DW'(ABORT_RDATA);
    end
  end

  // m_req/busy are decoded from the async-reset state so they drop the moment reset rises.
  assign m_req   = in_busy;
  assign busy    = ~in_idle;
  assign c_ack   = in_done & (owner == PORT_C);
  assign d_ack   = in_done & (owner == PORT_D);
  assign c_rdata = c_ack ? rdata_q : '0;
  assign d_rdata = d_ack ? rdata_q : '0;
  assign err     = in_done & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal cases plus random traffic against a transaction model.
// Latency: n/a.
// Backpressure: requesters hold req until their ack, memory ready is randomised with long stalls.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata, c_rdata, d_rdata;
  logic          c_ack, d_ack, err;
  logic          m_req, m_we, m_ready, owner, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .err(err), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level reference: one outstanding transaction, described by who won,
  // its fields, how many BUSY cycles elapsed and what it will return.
  bit          md_active, md_fin, md_win, md_we, md_owner, md_rr_last, md_err;
  logic [31:0] md_addr, md_wdata, md_held_rd, md_ret_rd;
  int          md_waits;
  bit          c_ack_seen, d_ack_seen;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      md_active = 0; md_fin = 0; md_win = 0; md_we = 0; md_owner = 0;
      md_rr_last = 1; md_err = 0; md_addr = 0; md_wdata = 0;
      md_held_rd = 0; md_ret_rd = 0; md_waits = 0;
      c_ack_seen = 0; d_ack_seen = 0;
      chk("rst_m_req", m_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_c_ack", c_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_owner", owner, 0);
      chk("rst_m_addr", m_addr, 0);
    end else begin
      chk("mdl_busy", busy, md_active);
      chk("mdl_m_req", m_req, md_active && !md_fin);
      chk("mdl_c_ack", c_ack, md_fin && md_win == 0);
      chk("mdl_d_ack", d_ack, md_fin && md_win == 1);
      chk("mdl_owner", owner, md_owner);
      chk("mdl_m_we", m_we, md_we);
      chk("mdl_m_addr", m_addr, md_addr);
      chk("mdl_m_wdata", m_wdata, md_wdata);
      if (md_fin) begin
        chk("mdl_err", err, md_err);
        if (md_win == 0) chk("mdl_c_rdata", c_rdata, md_ret_rd);
        else             chk("mdl_d_rdata", d_rdata, md_ret_rd);
      end
      c_ack_seen = c_ack;
      d_ack_seen = d_ack;
      // Advance the model using the inputs present during this cycle.
      if (!md_active) begin
        if (c_req || d_req) begin
          if (c_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            md_win = !md_rr_last;
`else
            md_win = 0;
`endif
          end else begin
            md_win = d_req;
          end
          md_rr_last = md_win;
          md_owner   = md_win;
          md_we      = md_win ? d_we : c_we;
          md_addr    = md_win ? d_addr : c_addr;
          md_wdata   = md_win ? d_wdata : c_wdata;
          md_waits   = 0;
          md_active  = 1;
        end
      end else if (!md_fin) begin
        md_waits++;
        if (m_ready) begin
          if (!md_we) md_held_rd = m_rdata;
          md_ret_rd = md_held_rd;
          md_err    = 0;
          md_fin    = 1;
        end else if (md_waits == MW) begin
          md_held_rd = 0;
          md_ret_rd  = 0;
          md_err     = 1;
          md_fin     = 1;
        end
      end else begin
        md_active = 0;
        md_fin    = 0;
      end
    end
  end

  int  ack_seq[4];
  int  n_acks;
  int  exp_seq[4];
  bit  stall;

  initial begin
    reset = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; m_ready = 0; m_rdata = 0;
    stall = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_m_req", m_req, 0);
    chk("reset_err", err, 0);
    chk("reset_c_rdata", c_rdata, 0);
    reset = 0;

    // C read at 0x100, ready on the first BUSY cycle.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    tick();
    chk("c_rd_m_req", m_req, 1);
    chk("c_rd_m_addr", m_addr, 32'h100);
    m_ready = 1; m_rdata = 32'h12345678;
    tick();
    chk("c_rd_ack", c_ack, 1);
    chk("c_rd_data", c_rdata, 32'h12345678);
    chk("c_rd_err", err, 0);
    chk("c_rd_d_ack", d_ack, 0);
    c_req = 0; m_ready = 0;
    tick();

    // D write with three wait states; fields must stay put throughout BUSY.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFEBABE;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("d_wr_m_req", m_req, 1);
      chk("d_wr_m_we", m_we, 1);
      chk("d_wr_m_addr", m_addr, 32'h40);
      chk("d_wr_m_wdata", m_wdata, 32'hCAFEBABE);
      chk("d_wr_early_ack", d_ack, 0);
      if (i == 4) m_ready = 1;
    end
    tick();
    chk("d_wr_ack", d_ack, 1);
    chk("d_wr_c_ack", c_ack, 0);
    chk("d_wr_err", err, 0);
    d_req = 0;
    // m_ready stays high through DONE and IDLE: it must be ignored there.
    tick();
    chk("rdy_done_busy", busy, 0);
    tick();
    chk("rdy_idle_busy", busy, 0);
    chk("rdy_idle_ack", c_ack | d_ack, 0);
    m_ready = 0;

    // Watchdog abort: no ready at all.
    c_req = 1; c_we = 0; c_addr = 32'h200;
    for (int i = 1; i <= MW; i++) begin
      tick();
      chk("wd_m_req", m_req, 1);
      chk("wd_no_ack", c_ack, 0);
    end
    tick();
    chk("wd_ack", c_ack, 1);
    chk("wd_err", err, 1);
    chk("wd_rdata", c_rdata, 0);
    c_req = 0;
    tick();
    c_req = 1; c_addr = 32'h300;
    tick();
    m_ready = 1; m_rdata = 32'hA5A50F0F;
    tick();
    chk("post_wd_ack", c_ack, 1);
    chk("post_wd_err", err, 0);
    chk("post_wd_rdata", c_rdata, 32'hA5A50F0F);
    c_req = 0; m_ready = 0;
    tick();

    // Reset in the middle of BUSY: m_req/busy fall at once, no ack.
    d_req = 1; d_we = 0; d_addr = 32'h80;
    tick();
    chk("mid_rst_pre", m_req, 1);
    reset = 1;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d_ack", d_ack, 0);
    d_req = 0;
    tick();
    chk("mid_rst_no_ack", d_ack, 0);
    tick();
    reset = 0;

    // Continuous tie straight after reset.
    c_req = 1; c_we = 0; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    m_ready = 1;
    n_acks = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if ((c_ack || d_ack) && n_acks < 4) begin
        ack_seq[n_acks] = d_ack ? 1 : 0;
        n_acks++;
      end
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    chk("tie_ack_count", n_acks, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_acks) chk("tie_order", ack_seq[k], exp_seq[k]);
    end
    c_req = 0; d_req = 0; m_ready = 0;
    tick();
    tick();

    // Random traffic, occasional long stalls and asynchronous resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) stall = ($urandom_range(3) == 0);
      m_ready = stall ? 1'b0 : ($urandom_range(2) == 0);
      m_rdata = $urandom;
      if (reset) reset = 0;
      else if ($urandom_range(699) == 0) reset = 1;
      if (!c_req) begin
        if ($urandom_range(2) == 0) begin
          c_req = 1; c_we = 1'($urandom_range(1)); c_addr = $urandom; c_wdata = $urandom;
        end
      end else if (c_ack_seen) begin
        if ($urandom_range(1) == 0) c_req = 0;
        else begin c_we = 1'($urandom_range(1)); c_addr = $urandom; c_wdata = $urandom; end
      end
      if (!d_req) begin
        if ($urandom_range(2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (d_ack_seen) begin
        if ($urandom_range(1) == 0) d_req = 0;
        else begin d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom; end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
